// File: rtl/riscv_decode_stage.sv
// Buffered decode stage: a DEPTH-entry instruction queue feeding a registered
// RV32I/Zicsr/mret (optionally RV32M) decoder with valid/ready on both sides.
module riscv_decode_stage #(
  parameter int DEPTH    = 4,
  parameter bit M_EXT_EN = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            in_instr_i,
  input  logic [31:0]            in_pc_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            out_pc_o,
  output logic [31:0]            out_instr_o,
  output logic [1:0]             a_sel_o,
  output logic [2:0]             b_sel_o,
  output logic [4:0]             alu_op_o,
  output logic                   mdu_o,
  output logic [2:0]             csr_op_o,
  output logic                   csr_we_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [2:0]             mem_size_o,
  output logic                   gpr_we_o,
  output logic [1:0]             wb_sel_o,
  output logic                   branch_o,
  output logic                   jal_o,
  output logic                   jalr_o,
  output logic                   mret_o,
  output logic                   illegal_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [CNT_W-1:0]       illegal_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6f, OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03, OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13, OPC_OP = 7'h33, OPC_MISC_MEM = 7'h0f, OPC_SYSTEM = 7'h73;
  localparam logic [31:0] MRET = 32'h30200073;

  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_EQ = 5'd10, ALU_NE = 5'd11;
  localparam logic [4:0] ALU_LT = 5'd12, ALU_GE = 5'd13, ALU_LTU = 5'd14, ALU_GEU = 5'd15;
  localparam logic [1:0] A_PC = 2'd1, A_ZERO = 2'd2;
  localparam logic [2:0] B_IMM_I = 3'd1, B_IMM_S = 3'd2, B_IMM_U = 3'd3, B_FOUR = 3'd4;
  localparam logic [1:0] WB_LSU = 2'd1, WB_CSR = 2'd2;

  typedef struct packed {
    logic [1:0] a_sel;
    logic [2:0] b_sel;
    logic [4:0] alu_op;
    logic       mdu;
    logic [2:0] csr_op;
    logic       csr_we;
    logic       mem_req;
    logic       mem_we;
    logic [2:0] mem_size;
    logic       gpr_we;
    logic [1:0] wb_sel;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       mret;
    logic       illegal;
  } ctrl_t;

  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      3'd7:    op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // An illegal word collapses to all-zero controls with only illegal set.
  function automatic ctrl_t decode(input logic [31:0] ins);
    ctrl_t      c;
    logic       ill;
    logic [2:0] f3;
    logic [6:0] f7;
    f3  = ins[14:12];
    f7  = ins[31:25];
    c   = '0;
    ill = 1'b0;
    case (ins[6:0])
      OPC_LUI:   begin c.a_sel = A_ZERO; c.b_sel = B_IMM_U; c.gpr_we = 1'b1; end
      OPC_AUIPC: begin c.a_sel = A_PC; c.b_sel = B_IMM_U; c.gpr_we = 1'b1; end
      OPC_JAL:   begin c.a_sel = A_PC; c.b_sel = B_FOUR; c.jal = 1'b1; c.gpr_we = 1'b1; end
      OPC_JALR: begin
        if (f3 == 3'd0) begin
          c.a_sel = A_PC; c.b_sel = B_FOUR; c.jalr = 1'b1; c.gpr_we = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      OPC_BRANCH: begin
        c.branch = 1'b1;
        case (f3)
          3'd0:    c.alu_op = ALU_EQ;
          3'd1:    c.alu_op = ALU_NE;
          3'd4:    c.alu_op = ALU_LT;
          3'd5:    c.alu_op = ALU_GE;
          3'd6:    c.alu_op = ALU_LTU;
          3'd7:    c.alu_op = ALU_GEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
          ill = 1'b1;
        end else begin
          c.b_sel = B_IMM_I; c.mem_req = 1'b1; c.mem_size = f3;
          c.gpr_we = 1'b1; c.wb_sel = WB_LSU;
        end
      end
      OPC_STORE: begin
        if (f3 > 3'd2) begin
          ill = 1'b1;
        end else begin
          c.b_sel = B_IMM_S; c.mem_req = 1'b1; c.mem_we = 1'b1; c.mem_size = f3;
        end
      end
      OPC_OP_IMM: begin
        c.b_sel  = B_IMM_I;
        c.gpr_we = 1'b1;
        if (f3 == 3'd1 && f7 != 7'h00) begin
          ill = 1'b1;
        end else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) begin
          ill = 1'b1;
        end else begin
          c.alu_op = alu_base(f3, (f3 == 3'd5) && (f7 == 7'h20));
        end
      end
      OPC_OP: begin
        c.gpr_we = 1'b1;
        if (f7 == 7'h00) begin
          c.alu_op = alu_base(f3, 1'b0);
        end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          c.alu_op = alu_base(f3, 1'b1);
        end else if (f7 == 7'h01 && M_EXT_EN) begin
          c.mdu = 1'b1; c.alu_op = {2'b00, f3};
        end else begin
          ill = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        if (f3 != 3'd0) begin
          ill = 1'b1;
        end else begin
          ill = 1'b0;
        end
      end
      OPC_SYSTEM: begin
        if (ins == MRET) begin
          c.mret = 1'b1;
        end else if (f3 == 3'd0 || f3 == 3'd4) begin
          ill = 1'b1;
        end else begin
          c.csr_op = f3; c.csr_we = 1'b1; c.gpr_we = 1'b1; c.wb_sel = WB_CSR;
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      c         = '0;
      c.illegal = 1'b1;
    end else begin
      c.illegal = 1'b0;
    end
    return c;
  endfunction

  logic [31:0]      mem_instr_q [DEPTH];
  logic [31:0]      mem_instr_d [DEPTH];
  logic [31:0]      mem_pc_q [DEPTH];
  logic [31:0]      mem_pc_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_pc_q, out_pc_d, out_instr_q, out_instr_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic             in_ready_s, push_s, pop_s;
  ctrl_t            head_ctrl_s;

  // Queue bookkeeping, output-register load and illegal counting.
  always_comb begin
    in_ready_s  = (count_q != FULL);
    push_s      = in_valid_i & in_ready_s;
    pop_s       = (count_q != '0) & (~out_valid_q | out_ready_i);
    head_ctrl_s = decode(mem_instr_q[rd_ptr_q]);
    mem_instr_d = mem_instr_q;
    mem_pc_d    = mem_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    ctrl_d      = ctrl_q;
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push_s) begin
        mem_instr_d[wr_ptr_q] = in_instr_i;
        mem_pc_d[wr_ptr_q]    = in_pc_i;
        wr_ptr_d              = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d    = rd_ptr_q + AW'(1);
        out_valid_d = 1'b1;
        out_pc_d    = mem_pc_q[rd_ptr_q];
        out_instr_d = mem_instr_q[rd_ptr_q];
        ctrl_d      = head_ctrl_s;
      end else if (out_ready_i) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
    // A word handed over on the flush edge still counts; flush never clears the counter.
    if (out_valid_q & out_ready_i & ctrl_q.illegal & (ill_cnt_q != CNT_MAX)) begin
      ill_cnt_d = ill_cnt_q + CNT_W'(1);
    end else begin
      ill_cnt_d = ill_cnt_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      ctrl_q      <= '0;
      ill_cnt_q   <= '0;
    end else begin
      mem_instr_q <= mem_instr_d;
      mem_pc_q    <= mem_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      ctrl_q      <= ctrl_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign in_ready_o    = in_ready_s;
  assign out_valid_o   = out_valid_q;
  assign out_pc_o      = out_pc_q;
  assign out_instr_o   = out_instr_q;
  assign a_sel_o       = ctrl_q.a_sel;
  assign b_sel_o       = ctrl_q.b_sel;
  assign alu_op_o      = ctrl_q.alu_op;
  assign mdu_o         = ctrl_q.mdu;
  assign csr_op_o      = ctrl_q.csr_op;
  assign csr_we_o      = ctrl_q.csr_we;
  assign mem_req_o     = ctrl_q.mem_req;
  assign mem_we_o      = ctrl_q.mem_we;
  assign mem_size_o    = ctrl_q.mem_size;
  assign gpr_we_o      = ctrl_q.gpr_we;
  assign wb_sel_o      = ctrl_q.wb_sel;
  assign branch_o      = ctrl_q.branch;
  assign jal_o         = ctrl_q.jal;
  assign jalr_o        = ctrl_q.jalr;
  assign mret_o        = ctrl_q.mret;
  assign illegal_o     = ctrl_q.illegal;
  assign count_o       = count_q;
  assign illegal_cnt_o = ill_cnt_q;
endmodule
